// File: rtl/multicycle_controller.sv
// Multi-cycle LEGv8 sequencer: fetches one instruction into IR, then walks
// DECODE/EXEC/MEM/WB, driving datapath fields and controls one state per cycle.
module multicycle_controller #(
   parameter logic [2:0] ALU_ADD   = 3'b010,
   parameter logic [2:0] ALU_SUB   = 3'b011,
   parameter logic [2:0] ALU_PASSB = 3'b000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   output logic        imem_req_o,
   input  logic        imem_valid_i,
   input  logic [31:0] instr_i,
   input  logic        dmem_ready_i,
   input  logic        zero_i,
   output logic [4:0]  rd_o,
   output logic [4:0]  rn_o,
   output logic [4:0]  rm_o,
   output logic [8:0]  daddr9_o,
   output logic [11:0] imm12_o,
   output logic [25:0] br_addr26_o,
   output logic [18:0] cond_addr19_o,
   output logic        reg2loc_o,
   output logic        reg_write_o,
   output logic        mem_write_o,
   output logic        mem_to_reg_o,
   output logic        alu_src_o,
   output logic [2:0]  alu_op_o,
   output logic        flag_write_o,
   output logic        pc_write_o,
   output logic [1:0]  pc_src_o,
   output logic        halted_o
);

   localparam logic [2:0] StFetch  = 3'd0;
   localparam logic [2:0] StDecode = 3'd1;
   localparam logic [2:0] StExec   = 3'd2;
   localparam logic [2:0] StMem    = 3'd3;
   localparam logic [2:0] StWb     = 3'd4;
   localparam logic [2:0] StHalt   = 3'd5;

   logic [2:0]  state_q, state_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] ir_vis;

   logic is_addi, is_adds, is_subs, is_ldur, is_stur, is_b, is_cbz, is_legal;
   logic in_op;

   assign is_addi  = (ir_q[31:22] == 10'b1001000100);
   assign is_adds  = (ir_q[31:21] == 11'b10101011000);
   assign is_subs  = (ir_q[31:21] == 11'b11101011000);
   assign is_ldur  = (ir_q[31:21] == 11'b11111000010);
   assign is_stur  = (ir_q[31:21] == 11'b11111000000);
   assign is_b     = (ir_q[31:26] == 6'b000101);
   assign is_cbz   = (ir_q[31:24] == 8'b10110100);
   assign is_legal = is_addi | is_adds | is_subs | is_ldur | is_stur | is_b | is_cbz;

   // Fields come only from IR so they stay stable while the fetch bus changes.
   assign ir_vis        = reset_i ? 32'd0 : ir_q;
   assign rd_o          = ir_vis[4:0];
   assign rn_o          = ir_vis[9:5];
   assign rm_o          = ir_vis[20:16];
   assign daddr9_o      = ir_vis[20:12];
   assign imm12_o       = ir_vis[21:10];
   assign br_addr26_o   = ir_vis[25:0];
   assign cond_addr19_o = ir_vis[23:5];

   assign in_op = (state_q == StExec) || (state_q == StMem) || (state_q == StWb);

   always_comb begin
      state_d      = state_q;
      ir_d         = ir_q;
      imem_req_o   = 1'b0;
      reg2loc_o    = in_op & ~(is_stur | is_cbz);
      alu_src_o    = in_op & (is_addi | is_ldur | is_stur);
      alu_op_o     = !in_op ? ALU_PASSB : is_subs ? ALU_SUB : is_cbz ? ALU_PASSB : ALU_ADD;
      reg_write_o  = 1'b0;
      mem_write_o  = 1'b0;
      mem_to_reg_o = 1'b0;
      flag_write_o = 1'b0;
      pc_write_o   = 1'b0;
      pc_src_o     = 2'b00;
      halted_o     = 1'b0;
      case (state_q)
         StFetch: begin
            imem_req_o = 1'b1;
            if (imem_valid_i) begin
               ir_d    = instr_i;
               state_d = StDecode;
            end
         end
         StDecode: begin
            if (is_b) begin
               pc_write_o = 1'b1;
               pc_src_o   = 2'b01;
               state_d    = StFetch;
            end else if (is_legal) begin
               state_d = StExec;
            end else begin
               state_d = StHalt;
            end
         end
         StExec: begin
            flag_write_o = is_adds | is_subs;
            if (is_cbz) begin
               pc_write_o = 1'b1;
               pc_src_o   = zero_i ? 2'b10 : 2'b00;
               state_d    = StFetch;
            end else if (is_ldur || is_stur) begin
               state_d = StMem;
            end else begin
               state_d = StWb;
            end
         end
         StMem: begin
            mem_write_o = is_stur;
            if (dmem_ready_i) begin
               if (is_stur) begin
                  pc_write_o = 1'b1;
                  state_d    = StFetch;
               end else begin
                  state_d = StWb;
               end
            end
         end
         StWb: begin
            reg_write_o  = 1'b1;
            mem_to_reg_o = is_ldur;
            pc_write_o   = 1'b1;
            state_d      = StFetch;
         end
         StHalt: halted_o = 1'b1;
         default: state_d = StFetch;
      endcase
      // Reset aborts the instruction in the same cycle: nothing may be written.
      if (reset_i) begin
         imem_req_o   = 1'b0;
         reg2loc_o    = 1'b0;
         alu_src_o    = 1'b0;
         alu_op_o     = 3'b000;
         reg_write_o  = 1'b0;
         mem_write_o  = 1'b0;
         mem_to_reg_o = 1'b0;
         flag_write_o = 1'b0;
         pc_write_o   = 1'b0;
         pc_src_o     = 2'b00;
         halted_o     = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StFetch;
         ir_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

endmodule
